// File: rtl/uart_bridge_pkg.sv
// rtl/uart_bridge_pkg.sv - shared state encoding and default UART register map for the tx bridge
package uart_bridge_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_POLL  = 2'd1,
      ST_WRITE = 2'd2,
      ST_HOLD  = 2'd3
   } bridge_state_e;

   localparam logic [2:0] UART_ADDR_UDR    = 3'd0;
   localparam logic [2:0] UART_ADDR_STATUS = 3'd1;
   localparam int         UART_UDRE_BIT    = 5;

endpackage

// File: rtl/uart_bridge_fifo.sv
// rtl/uart_bridge_fifo.sv - single-clock byte FIFO with registered occupancy
// Caller must not push while full or pop while empty.
module uart_bridge_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_data,
   input  logic                       i_pop,
   output logic [WIDTH-1:0]           o_head,
   output logic [$clog2(DEPTH):0]     o_level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q;
   logic [AW-1:0]    rd_q;
   logic [AW:0]      level_q;

   always_ff @(posedge i_clk) begin
      if (i_push) begin
         mem_q[wr_q] <= i_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         wr_q    <= '0;
         rd_q    <= '0;
         level_q <= '0;
      end else begin
         if (i_push) begin
            wr_q <= wr_q + 1'b1;
         end
         if (i_pop) begin
            rd_q <= rd_q + 1'b1;
         end
         case ({i_push, i_pop})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: level_q <= level_q;
         endcase
      end
   end

   assign o_head  = mem_q[rd_q];
   assign o_level = level_q;

endmodule

// File: rtl/uart_tx_bridge.sv
// rtl/uart_tx_bridge.sv - stream-to-UART bridge: buffers bytes, polls UDRE, writes data register
// Optional UART_TX_BRIDGE_STATS_EN adds a 16-bit o_tx_count of bytes written.
module uart_tx_bridge
   import uart_bridge_pkg::*;
#(
   parameter int                DEPTH       = 8,
   parameter int                ADDR_W      = 3,
   parameter logic [ADDR_W-1:0] ADDR_UDR    = ADDR_W'(UART_ADDR_UDR),
   parameter logic [ADDR_W-1:0] ADDR_STATUS = ADDR_W'(UART_ADDR_STATUS),
   parameter int                UDRE_BIT    = UART_UDRE_BIT,
   parameter int                HOLDOFF     = 2
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic [7:0]             i_s_data,
   input  logic                   i_s_valid,
   output logic                   o_s_ready,
   output logic                   o_bus_we,
   output logic [ADDR_W-1:0]      o_bus_address,
   output logic [7:0]             o_bus_data,
   input  logic [7:0]             i_bus_data,
   output logic [$clog2(DEPTH):0] o_level,
`ifdef UART_TX_BRIDGE_STATS_EN
   output logic [15:0]            o_tx_count,
`endif
   output logic                   o_busy
);

   localparam int LVL_W  = $clog2(DEPTH) + 1;
   localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

   bridge_state_e     state_q, state_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              push;
   logic              pop;
   logic              fifo_nonempty;
   logic [7:0]        head;
   logic              unused_bus_bits;

   assign o_s_ready     = (o_level != LVL_W'(DEPTH));
   assign push          = i_s_valid && o_s_ready;
   assign pop           = (state_q == ST_WRITE);
   assign fifo_nonempty = (o_level != '0);
   assign o_busy        = fifo_nonempty || (state_q != ST_IDLE);
   assign unused_bus_bits = ^i_bus_data;

   uart_bridge_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (push),
      .i_data  (i_s_data),
      .i_pop   (pop),
      .o_head  (head),
      .o_level (o_level)
   );

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
      end
   end

   // Status address stays up in every non-WRITE state so a registered UART read path is settled when sampled.
   always_comb begin
      state_d       = state_q;
      hold_d        = hold_q;
      o_bus_we      = 1'b0;
      o_bus_address = ADDR_STATUS;
      o_bus_data    = '0;
      case (state_q)
         ST_IDLE: begin
            if (fifo_nonempty) begin
               state_d = ST_POLL;
            end
         end
         ST_POLL: begin
            if (i_bus_data[UDRE_BIT]) begin
               state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            o_bus_we      = 1'b1;
            o_bus_address = ADDR_UDR;
            o_bus_data    = head;
            hold_d        = HOLD_W'(HOLDOFF - 1);
            state_d       = ST_HOLD;
         end
         ST_HOLD: begin
            if (hold_q == '0) begin
               state_d = fifo_nonempty ? ST_POLL : ST_IDLE;
            end else begin
               hold_d = hold_q - 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

`ifdef UART_TX_BRIDGE_STATS_EN
   logic [15:0] tx_count_q;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         tx_count_q <= '0;
      end else if (state_q == ST_WRITE) begin
         tx_count_q <= tx_count_q + 16'd1;
      end
   end

   assign o_tx_count = tx_count_q;
`else
`endif

endmodule

// File: doc/uart_tx_bridge.md
# uart_tx_bridge

Byte-stream front end for the `uart` core, sitting directly upstream of its register bus. Accepts bytes over a valid/ready stream and buffers them in a FIFO. Each byte is written into the UART data register only after the bridge polls the status register and sees the data-register-empty flag set. Firmware or a packet engine can then stream bytes without handling UART flow control.

## Interface
- `DEPTH`, 8: FIFO depth in bytes; power of two, ≥2.
- `ADDR_W`, 3: bus address width.
- `ADDR_UDR`, 3'd0: UART data register address.
- `ADDR_STATUS`, 3'd1: UART status register address.
- `UDRE_BIT`, 5: bit index of data-register-empty in the status register.
- `HOLDOFF`, 2: cycles after a write before the status is polled again; ≥1.
- `i_clk` in 1: single clock; all state updates on rising edge.
- `i_rst_n` in 1: reset, synchronous, active-low.
- `i_s_data` in 8: stream byte.
- `i_s_valid` in 1: stream byte valid.
- `o_s_ready` in/out: out 1; bridge can accept a byte (FIFO not full).
- `o_bus_we` out 1: connects to uart `i_we`.
- `o_bus_address` out ADDR_W: connects to uart `i_address`.
- `o_bus_data` out 8: connects to uart `i_data`.
- `i_bus_data` in 8: connects to uart `o_data`.
- `o_level` out $clog2(DEPTH)+1: FIFO occupancy.
- `o_busy` out 1: FIFO non-empty or FSM not in IDLE.

## Operation
- Push occurs when `i_s_valid && o_s_ready` at a clock edge. `o_s_ready = (o_level != DEPTH)`, combinational from registered occupancy.
- The FSM has four states.
  - IDLE: address = ADDR_STATUS, we=0. If the FIFO is non-empty, go to POLL.
  - POLL: address = ADDR_STATUS, we=0. Sample `i_bus_data[UDRE_BIT]` at the edge. If it is 1, go to WRITE; otherwise stay in POLL.
  - WRITE: we=1, address = ADDR_UDR, `o_bus_data` = FIFO head. The FIFO pops at this edge. Load the holdoff counter with HOLDOFF-1 and go to HOLD.
  - HOLD: address = ADDR_STATUS, we=0. Decrement the counter. At 0, go to POLL if the FIFO is non-empty, otherwise go to IDLE.
- `o_bus_data` = 0 outside WRITE.
- Simultaneous push and pop in WRITE: occupancy is unchanged, and the new byte is stored behind the popped head.
- Push while full: not possible, since ready is low. A valid byte held while ready is low is kept by the source, not dropped.
- Pointers wrap modulo DEPTH. Occupancy covers 0..DEPTH.
- Reset values: state IDLE, `o_bus_we`=0, `o_bus_address`=ADDR_STATUS, `o_bus_data`=0, `o_level`=0, `o_s_ready`=1, `o_busy`=0.
- Reset asserted mid-operation flushes the FIFO and returns to IDLE at that edge. A write already strobed is not retracted.

## Timing
- Byte pushed into an empty FIFO at edge E0, UART idle: IDLE during cycle E0..E1, POLL during E1..E2, WRITE (`o_bus_we`=1) during E2..E3.
- Minimum spacing between consecutive write strobes is HOLDOFF+2 cycles: 4 with the default.
- The status address is held stable for at least one full cycle before being sampled. This supports a UART read path with either combinational or one-cycle registered `o_data`.
- `o_bus_we` is high for exactly one cycle per byte.

## Configuration
- `UART_TX_BRIDGE_STATS_EN` defined: adds output `o_tx_count` (16 bits). It increments on every WRITE cycle, wraps 0xFFFF→0, and resets to 0.
- `UART_TX_BRIDGE_STATS_EN` undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Package `uart_bridge_pkg` holds:
  - the state enum (IDLE, POLL, WRITE, HOLD);
  - default register address constants;
  - the UDRE bit index constant.
- Sub-module `uart_bridge_fifo`: synchronous single-clock FIFO with push/pop, head data, and level outputs.
- The FSM and bus muxing live in `uart_tx_bridge`.

## Test plan
- Reset: hold `i_rst_n`=0 for 2 cycles → all outputs at reset values, `o_s_ready`=1.
- Single byte 0xA5, status returns 0x20 → `o_bus_we`=1 with address 0, data 0xA5, exactly 2 cycles after the push edge. `o_level` returns to 0.
- Status returns 0x00 for 10 cycles, then 0x20 → bridge stays in POLL and writes no byte until the flag appears; then 0x3C is written once.
- Push 9 bytes 0x01..0x09 with the flag held 0 → `o_s_ready` falls after the 8th byte and `o_level`=8. Releasing the flag yields writes 0x01..0x08 in order, 4 cycles apart, then the 9th byte.
- Push and pop in the same cycle with the FIFO at level 3 → level stays 3, and byte order is preserved.
- Reset while in POLL with 5 bytes queued → FIFO empties, `o_bus_we` stays 0. With the macro defined, `o_tx_count` reads 0.
